// File: rtl/timer_bank.sv
// Bank of NUM_CH countdown timers sharing one tick prescaler.
// Define TIMER_BANK_PAUSE_EN to add a per-channel pause input.
module timer_bank_ch #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             pause,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired,
  output logic             timeout_pulse
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             expired_q, expired_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = period_q;
    mode_d    = mode_q;
    expired_d = expired_q;
    pulse_d   = 1'b0;
    if (start) begin
      period_d = load_val;
      mode_d   = periodic;
      if (load_val == '0) begin
        // zero period times out immediately and never reloads
        state_d   = S_DONE;
        count_d   = '0;
        expired_d = 1'b1;
        pulse_d   = 1'b1;
      end else begin
        state_d   = S_RUN;
        count_d   = load_val;
        expired_d = 1'b0;
      end
    end else if (state_q == S_RUN) begin
      if (stop) begin
        state_d = S_IDLE;
      end else if (tick && !pause) begin
        if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          expired_d = 1'b1;
          pulse_d   = 1'b1;
          if (mode_q) begin
            count_d = period_q;
          end else begin
            count_d = '0;
            state_d = S_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      period_q  <= '0;
      mode_q    <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      mode_q    <= mode_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
    end
  end

  assign count         = count_q;
  assign running       = (state_q == S_RUN);
  assign expired       = expired_q;
  assign timeout_pulse = pulse_q;
endmodule

module timer_bank #(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
`ifdef TIMER_BANK_PAUSE_EN
  input  logic [NUM_CH-1:0]       pause,
`endif
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       expired,
  output logic [NUM_CH-1:0]       timeout_pulse
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;
  logic [NUM_CH-1:0] pause_w;

`ifdef TIMER_BANK_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = '0;
`endif

  assign tick = (presc_q == PMAX);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_bank_ch #(.WIDTH(WIDTH)) u_ch (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .start        (start[i]),
      .stop         (stop[i]),
      .periodic     (periodic[i]),
      .pause        (pause_w[i]),
      .load_val     (load_val[i*WIDTH +: WIDTH]),
      .count        (count[i*WIDTH +: WIDTH]),
      .running      (running[i]),
      .expired      (expired[i]),
      .timeout_pulse(timeout_pulse[i])
    );
  end
endmodule
